// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Purpose  : Shared SHA-256 constants, schedule FSM state type and the
//            small-sigma / byte-swap helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_ROUND  = 2'd1,
      ST_UPDATE = 2'd2
   } sched_state_t;

   localparam logic [31:0] K_TABLE [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // sigma0(x) = rotr7 ^ rotr18 ^ shr3
   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // sigma1(x) = rotr17 ^ rotr19 ^ shr10
   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Reverse the byte order of a 32-bit word
   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// ============================================================================
// Module   : sha256_k_rom
// Purpose  : Combinational round-constant lookup, K[idx] for idx = 0..63.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0]  idx,
   output logic [31:0] k
);

   assign k = K_TABLE[idx];

endmodule : sha256_k_rom
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Purpose  : Buffers one 16-word block, expands the 64-word message schedule
//            in a sliding 16-word window and sequences 64 rounds plus one
//            hash-update cycle for the downstream compressor.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule
   import sha256_pkg::*;
#(
   parameter bit BYTE_SWAP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [31:0] w_out,
   output logic [31:0] k_out,
   output logic        cmp_enable,
   output logic        cmp_update,
   output logic [5:0]  round_idx,
   output logic        busy,
   output logic        block_done
);

   sched_state_t state, state_nxt;
   logic [3:0]   cnt;
   logic [5:0]   rnd;
   logic [31:0]  win [0:15];
   logic [31:0]  in_word;
   logic [31:0]  k_rom_val;
   logic [31:0]  w_next;

   generate
      if (BYTE_SWAP) begin : g_swap
         assign in_word = bswap32(s_data);
      end else begin : g_pass
         assign in_word = s_data;
      end
   endgenerate

   sha256_k_rom u_k_rom (
      .idx (rnd),
      .k   (k_rom_val)
   );

   // W[t+16] from the current window, where win[0] holds W[t]
   assign w_next    = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
   assign round_idx = rnd;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   // Next-state decode and state-derived control outputs
   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      cmp_enable = 1'b0;
      cmp_update = 1'b0;
      busy       = 1'b0;
      w_out      = 32'd0;
      k_out      = 32'd0;
      case (state)
         ST_LOAD: begin
            s_ready = 1'b1;
            if (s_valid && (cnt == 4'd15)) state_nxt = ST_ROUND;
         end
         ST_ROUND: begin
            cmp_enable = 1'b1;
            busy       = 1'b1;
            w_out      = win[0];
            k_out      = k_rom_val;
            if (rnd == 6'd63) state_nxt = ST_UPDATE;
         end
         ST_UPDATE: begin
            cmp_enable = 1'b1;
            cmp_update = 1'b1;
            busy       = 1'b1;
            state_nxt  = ST_LOAD;
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   // Word count, round index and the block_done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= 4'd0;
         rnd        <= 6'd0;
         block_done <= 1'b0;
      end else begin
         block_done <= (state == ST_UPDATE);
         case (state)
            ST_LOAD: begin
               rnd <= 6'd0;
               if (s_valid) cnt <= cnt + 4'd1;
            end
            ST_ROUND: rnd <= rnd + 6'd1;
            default: begin
               cnt <= 4'd0;
               rnd <= 6'd0;
            end
         endcase
      end
   end

   // Window: filled by index during LOAD, slides one word per round
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) win[i] <= 32'd0;
      end else if ((state == ST_LOAD) && s_valid) begin
         win[cnt] <= in_word;
      end else if (state == ST_ROUND) begin
         for (int i = 0; i < 15; i++) win[i] <= win[i+1];
         win[15] <= w_next;
      end
   end

endmodule : sha256_msg_schedule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Purpose  : Directed self-checking bench; a behavioural compressor consumes
//            the w/k/enable/update stream so digests can be checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = 32'd0;
   logic        s_valid = 1'b0;
   logic        s_ready, cmp_enable, cmp_update, busy, block_done;
   logic [31:0] w_out, k_out;
   logic [5:0]  round_idx;

   // Byte-swapping instance fed the same stream in little-endian order
   logic [31:0] s_data_sw;
   logic        s_ready_sw, cmp_enable_sw, cmp_update_sw, busy_sw, block_done_sw;
   logic [31:0] w_out_sw, k_out_sw;
   logic [5:0]  round_idx_sw;
   assign s_data_sw = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};

   always #5 clk = ~clk;

   sha256_msg_schedule #(.BYTE_SWAP(1'b0)) u_dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .w_out(w_out), .k_out(k_out), .cmp_enable(cmp_enable), .cmp_update(cmp_update),
      .round_idx(round_idx), .busy(busy), .block_done(block_done)
   );

   sha256_msg_schedule #(.BYTE_SWAP(1'b1)) u_dut_sw (
      .clk(clk), .rst(rst), .s_data(s_data_sw), .s_valid(s_valid), .s_ready(s_ready_sw),
      .w_out(w_out_sw), .k_out(k_out_sw), .cmp_enable(cmp_enable_sw), .cmp_update(cmp_update_sw),
      .round_idx(round_idx_sw), .busy(busy_sw), .block_done(block_done_sw)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- behavioural compressor ----------------
   localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   logic [31:0] hs [8];
   logic [31:0] wk [8];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] t1_of(input logic [31:0] e, f, g, h, k, w);
      return h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
   endfunction
   function automatic logic [31:0] t2_of(input logic [31:0] a, b, c);
      return big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) hs[i] <= IV[i];
      end else if (!cmp_enable) begin
         for (int i = 0; i < 8; i++) wk[i] <= hs[i];
      end else if (cmp_update) begin
         for (int i = 0; i < 8; i++) hs[i] <= hs[i] + wk[i];
      end else begin
         wk[0] <= t1_of(wk[4], wk[5], wk[6], wk[7], k_out, w_out) + t2_of(wk[0], wk[1], wk[2]);
         wk[1] <= wk[0];
         wk[2] <= wk[1];
         wk[3] <= wk[2];
         wk[4] <= wk[3] + t1_of(wk[4], wk[5], wk[6], wk[7], k_out, w_out);
         wk[5] <= wk[4];
         wk[6] <= wk[5];
         wk[7] <= wk[6];
      end
   end

   // ---------------- output monitor (negedge) ----------------
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] wq [$];
   int          done_q [$];
   int          en_run, last_run, upd_pos, upd_cnt, upd_cyc;
   int          bad_rdy, bad_idle, bad_idx, sw_bad;
   logic [31:0] k_first, k_last;

   always @(negedge clk) begin
      if (rst) begin
         en_run = 0;
      end else begin
         if (cmp_enable) en_run++;
         else if (en_run != 0) begin
            last_run = en_run;
            en_run   = 0;
         end
         if (cmp_update) begin
            upd_pos = en_run;
            upd_cnt++;
            upd_cyc = cyc;
         end
         if (cmp_enable && !cmp_update) begin
            wq.push_back(w_out);
            if (round_idx != 6'(en_run - 1)) bad_idx++;
            if (round_idx == 6'd0)  k_first = k_out;
            if (round_idx == 6'd63) k_last  = k_out;
         end else if (round_idx != 6'd0 || w_out != 32'd0 || k_out != 32'd0) begin
            bad_idle++;
         end
         if (busy && s_ready) bad_rdy++;
         if (busy != cmp_enable) bad_rdy++;
         if (block_done) done_q.push_back(cyc);
         if (w_out_sw !== w_out || cmp_enable_sw !== cmp_enable || s_ready_sw !== s_ready) sw_bad++;
      end
   end

   task automatic clear_stats();
      wq.delete();
      done_q.delete();
      last_run = 0;
      upd_pos  = 0;
      upd_cnt  = 0;
      upd_cyc  = -10;
      k_first  = 32'd0;
      k_last   = 32'd0;
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      s_valid = 1'b0;
      clear_stats();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Feed 16 words; bubbly uses a valid pattern 1,0,0,1,0,0,...
   int bad_en;
   task automatic load_block(input logic [31:0] b [16], input bit bubbly, output int first_cyc);
      int  i  = 0;
      int  ph = 0;
      bit  acc;
      first_cyc = -1;
      while (i < 16 && ph < 400) begin
         s_data  = b[i];
         s_valid = bubbly ? (ph % 3 == 0) : 1'b1;
         @(negedge clk);
         if (i > 0 && cmp_enable) bad_en++;
         acc = s_valid && s_ready;
         if (acc && i == 0) first_cyc = cyc;
         @(posedge clk);
         #1;
         if (acc) i++;
         ph++;
      end
      s_valid = 1'b0;
      if (i < 16) check_eq("load_timeout", 32'(i), 32'd16);
   endtask

   task automatic wait_done();
      int n = 0;
      while (n < 150) begin
         @(negedge clk);
         if (block_done) break;
         n++;
      end
      if (n >= 150) check_eq("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   logic [31:0] abc_blk [16];
   logic [31:0] blk1 [16];
   logic [31:0] blk2 [16];
   logic [31:0] ref_w [64];
   int          fc, diffs, n;

   initial begin
      for (int i = 0; i < 16; i++) begin
         abc_blk[i] = 32'd0;
         blk2[i]    = 32'd0;
      end
      abc_blk[0]  = 32'h61626380;
      abc_blk[15] = 32'h00000018;
      blk1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      blk2[15] = 32'h000001c0;
      bad_en = 0; bad_rdy = 0; bad_idle = 0; bad_idx = 0; sw_bad = 0;
      clear_stats();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_s_ready",    32'(s_ready), 32'd1);
      check_eq("rst_cmp_enable", 32'(cmp_enable), 32'd0);
      check_eq("rst_cmp_update", 32'(cmp_update), 32'd0);
      check_eq("rst_busy",       32'(busy), 32'd0);
      check_eq("rst_block_done", 32'(block_done), 32'd0);
      check_eq("rst_round_idx",  32'(round_idx), 32'd0);
      check_eq("rst_w_k",        w_out | k_out, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // "abc" block with control timing
      load_block(abc_blk, 1'b0, fc);
      wait_done();
      check_eq("abc_nw",      32'(wq.size()), 32'd64);
      check_eq("abc_w16",     wq[16], 32'h61626380);
      check_eq("abc_w17",     wq[17], 32'h000f0000);
      check_eq("abc_k0",      k_first, 32'h428a2f98);
      check_eq("abc_k63",     k_last,  32'hc67178f2);
      check_eq("en_run_len",  32'(last_run), 32'd65);
      check_eq("upd_pos",     32'(upd_pos), 32'd65);
      check_eq("upd_count",   32'(upd_cnt), 32'd1);
      check_eq("done_count",  32'(done_q.size()), 32'd1);
      check_eq("done_timing", 32'(done_q[0]), 32'(upd_cyc + 1));
      check_eq("done_single", 32'(block_done), 32'd0);
      check_eq("abc_h0",      hs[0], 32'hba7816bf);
      check_eq("abc_h7",      hs[7], 32'hf20015ad);
      for (int i = 0; i < 64; i++) ref_w[i] = wq[i];

      // Bubbly input
      reset_dut();
      bad_en = 0;
      load_block(abc_blk, 1'b1, fc);
      wait_done();
      diffs = 0;
      for (int i = 0; i < 64; i++) if (i >= wq.size() || wq[i] !== ref_w[i]) diffs++;
      check_eq("bubbly_w_diffs", 32'(diffs), 32'd0);
      check_eq("bubbly_en_early", 32'(bad_en), 32'd0);
      check_eq("bubbly_h0", hs[0], 32'hba7816bf);

      // Reset at round 30, then rerun
      reset_dut();
      load_block(abc_blk, 1'b0, fc);
      n = 0;
      while (!(cmp_enable && round_idx == 6'd30) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_round30", 32'(round_idx), 32'd30);
      rst = 1'b1;
      #1;
      check_eq("midrst_enable", 32'(cmp_enable), 32'd0);
      check_eq("midrst_ready",  32'(s_ready), 32'd1);
      check_eq("midrst_idx",    32'(round_idx), 32'd0);
      check_eq("midrst_w",      w_out, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      clear_stats();
      load_block(abc_blk, 1'b0, fc);
      wait_done();
      check_eq("rerun_h0", hs[0], 32'hba7816bf);
      check_eq("rerun_h7", hs[7], 32'hf20015ad);

      // Two-block message, next word held valid through ROUND/UPDATE
      reset_dut();
      bad_rdy = 0;
      load_block(blk1, 1'b0, fc);
      load_block(blk2, 1'b0, fc);
      check_eq("hold_accept_cyc", 32'(fc), (done_q.size() > 0) ? 32'(done_q[0]) : 32'hffffffff);
      wait_done();
      check_eq("two_done_count", 32'(done_q.size()), 32'd2);
      check_eq("two_h0", hs[0], 32'h248d6a61);
      check_eq("two_h7", hs[7], 32'h19db06c1);
      check_eq("ready_while_busy", 32'(bad_rdy), 32'd0);

      // Whole-run invariants
      check_eq("idle_outputs", 32'(bad_idle), 32'd0);
      check_eq("round_idx_seq", 32'(bad_idx), 32'd0);
      check_eq("byteswap_inst", 32'(sw_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sha256_msg_schedule
`default_nettype wire
